mem_stage_lsu: RTL and testbench

//  Parametrised RV64 MEM pipeline stage. Resolves branches and jumps, and executes

---
 rtl/rv_pkg.sv | 32 +++
 rtl/lsu_align.sv | 70 +++++++
 rtl/mem_stage_lsu.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// RV64 opcode/funct3 constants and LSU state
// shared by the MEM stage and its helpers.
package rv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_HOLD = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Access-size decode, misalignment check, store lane
// steering and load extract/extension.
module lsu_align
   import rv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]        funct3,
   input  logic [2:0]        addr_lo,
   input  logic [XLEN-1:0]   sr2,
   input  logic [XLEN-1:0]   rdata,
   output logic              misaligned,
   output logic [XLEN/8-1:0] wstrb,
   output logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   ldata
);

   localparam int SW = XLEN / 8;
   localparam int OW = $clog2(SW);

   logic [OW-1:0]   off;
   logic [7:0]      base;
   logic [XLEN-1:0] sh;

   assign off = addr_lo[OW-1:0];

   always_comb begin
      misaligned = 1'b0;
      base       = 8'h01;
      wdata      = sr2;
      case (funct3[1:0])
         2'd0: begin
            base  = 8'h01;
            wdata = {SW{sr2[7:0]}};
         end
         2'd1: begin
            misaligned = addr_lo[0];
            base       = 8'h03;
            wdata      = {(XLEN/16){sr2[15:0]}};
         end
         2'd2: begin
            misaligned = |addr_lo[1:0];
            base       = 8'h0F;
            wdata      = {(XLEN/32){sr2[31:0]}};
         end
         default: begin
            // doubleword access does not exist on RV32
            misaligned = (XLEN == 32) || (|addr_lo);
            base       = 8'hFF;
            wdata      = sr2;
         end
      endcase
   end

   assign wstrb = SW'(base) << off;
   assign sh    = rdata >> {off, 3'b000};

   always_comb begin
      case (funct3)
         F3_LB:   ldata = XLEN'($signed(sh[7:0]));
         F3_LH:   ldata = XLEN'($signed(sh[15:0]));
         F3_LW:   ldata = XLEN'($signed(sh[31:0]));
         F3_LBU:  ldata = XLEN'(sh[7:0]);
         F3_LHU:  ldata = XLEN'(sh[15:0]);
         F3_LWU:  ldata = XLEN'(sh[31:0]);
         default: ldata = sh;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: branch resolve, load/store over a
// valid/ready data port, WB register slice.
module mem_stage_lsu
   import rv_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int ILEN    = 32,
   parameter int RID_W   = 5,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              WB_STALL,
   input  logic              MEM_V,
   input  logic [ILEN-1:0]   MEM_IR,
   input  logic [XLEN-1:0]   MEM_NPC,
   input  logic [XLEN-1:0]   MEM_ALU_RESULT,
   input  logic [XLEN-1:0]   MEM_SR1,
   input  logic [XLEN-1:0]   MEM_SR2,
   input  logic [XLEN-1:0]   MEM_RFD,
   input  logic [XLEN-1:0]   MEM_CSRFD,
   input  logic [RID_W-1:0]  MEM_DRID,
   input  logic              MEM_ECALL,
   output logic              DMEM_REQ,
   input  logic              DMEM_READY,
   output logic              DMEM_WE,
   output logic [XLEN-1:0]   DMEM_ADDR,
   output logic [XLEN-1:0]   DMEM_WDATA,
   output logic [XLEN/8-1:0] DMEM_WSTRB,
   input  logic              DMEM_RVALID,
   input  logic [XLEN-1:0]   DMEM_RDATA,
   input  logic              DMEM_RERR,
   output logic              WB_V,
   output logic [ILEN-1:0]   WB_IR,
   output logic [XLEN-1:0]   WB_NPC,
   output logic [XLEN-1:0]   WB_ALU_RESULT,
   output logic [XLEN-1:0]   WB_MEM_RESULT,
   output logic [XLEN-1:0]   WB_RFD,
   output logic [XLEN-1:0]   WB_CSRFD,
   output logic [RID_W-1:0]  WB_DRID,
   output logic              WB_ECALL,
   output logic              WB_PC_MUX,
   output logic              MEM_LAM,
   output logic              MEM_LAF,
   output logic              MEM_SAM,
   output logic              MEM_SAF,
   output logic              MEM_STALL
);

   localparam int SW = XLEN / 8;
   localparam int OW = $clog2(SW);
   localparam int TW = $clog2(TIMEOUT + 1);

   lsu_state_t      state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [XLEN-1:0] buf_q, buf_d;
   logic            buf_err_q, buf_err_d;

   logic            wb_v_q, wb_v_d;
   logic [ILEN-1:0] wb_ir_q, wb_ir_d;
   logic [XLEN-1:0] wb_npc_q, wb_npc_d;
   logic [XLEN-1:0] wb_alu_q, wb_alu_d;
   logic [XLEN-1:0] wb_mem_q, wb_mem_d;
   logic [XLEN-1:0] wb_rfd_q, wb_rfd_d;
   logic [XLEN-1:0] wb_csrfd_q, wb_csrfd_d;
   logic [RID_W-1:0] wb_drid_q, wb_drid_d;
   logic            wb_ecall_q, wb_ecall_d;
   logic            lam_q, lam_d, sam_q, sam_d;
   logic            laf_q, laf_d, saf_q, saf_d;

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic            is_ld, is_st, mis, mem_op;
   logic [SW-1:0]   st_strb;
   logic [XLEN-1:0] st_data, ld_data;
   logic            timeout, mem_done, resp_err;
   logic [XLEN-1:0] resp_data;
   logic            br_eq, br_lt, br_ltu, br_taken;
   logic            cap, cap_err, cap_mis;
   logic [XLEN-1:0] cap_data;
   logic            unused;

   assign opc    = MEM_IR[6:0];
   assign f3     = MEM_IR[14:12];
   assign unused = ^{MEM_IR[ILEN-1:15], MEM_IR[11:7]};
   assign is_ld  = MEM_V && (opc == OP_LOAD);
   assign is_st  = MEM_V && (opc == OP_STORE);
   assign mem_op = (is_ld || is_st) && !mis;

   lsu_align #(.XLEN(XLEN)) u_align (
      .funct3     (f3),
      .addr_lo    (MEM_ALU_RESULT[2:0]),
      .sr2        (MEM_SR2),
      .rdata      (DMEM_RDATA),
      .misaligned (mis),
      .wstrb      (st_strb),
      .wdata      (st_data),
      .ldata      (ld_data)
   );

   // an in-time response wins over a coincident timeout
   assign timeout   = (timer_q == TW'(TIMEOUT));
   assign mem_done  = (state_q == S_RESP) && (DMEM_RVALID || timeout);
   assign resp_err  = DMEM_RVALID ? DMEM_RERR : 1'b1;
   assign resp_data = (DMEM_RVALID && !DMEM_RERR && is_ld)
                    ? ld_data : '0;

   assign br_eq  = (MEM_SR1 == MEM_SR2);
   assign br_lt  = ($signed(MEM_SR1) < $signed(MEM_SR2));
   assign br_ltu = (MEM_SR1 < MEM_SR2);

   always_comb begin
      case (f3)
         F3_BEQ:  br_taken = br_eq;
         F3_BNE:  br_taken = !br_eq;
         F3_BLT:  br_taken = br_lt;
         F3_BGE:  br_taken = !br_lt;
         F3_BLTU: br_taken = br_ltu;
         F3_BGEU: br_taken = !br_ltu;
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      WB_PC_MUX = 1'b0;
      if (MEM_V) begin
         unique case (1'b1)
            (opc == OP_JAL),
            (opc == OP_JALR):   WB_PC_MUX = 1'b1;
            (opc == OP_BRANCH): WB_PC_MUX = br_taken;
            default:            WB_PC_MUX = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (mem_op) state_d = DMEM_READY ? S_RESP : S_REQ;
         S_REQ:  if (DMEM_READY) state_d = S_RESP;
         S_RESP: if (mem_done) state_d = WB_STALL ? S_HOLD : S_IDLE;
         S_HOLD: if (!WB_STALL) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      DMEM_REQ  = !RESET && (((state_q == S_IDLE) && mem_op)
                          || (state_q == S_REQ));
      MEM_STALL = WB_STALL
               || ((state_q == S_IDLE) && mem_op)
               || (state_q == S_REQ)
               || ((state_q == S_RESP) && !mem_done);
   end

   assign DMEM_WE    = is_st;
   assign DMEM_ADDR  = {MEM_ALU_RESULT[XLEN-1:OW], {OW{1'b0}}};
   assign DMEM_WDATA = st_data;
   assign DMEM_WSTRB = is_st ? st_strb : '0;

   always_comb begin
      timer_d   = '0;
      buf_d     = buf_q;
      buf_err_d = buf_err_q;
      cap       = 1'b0;
      cap_data  = '0;
      cap_err   = 1'b0;
      cap_mis   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cap     = !mem_op && !WB_STALL;
            cap_mis = mis;
         end
         S_RESP: begin
            if (!mem_done) begin
               timer_d = timer_q + TW'(1);
            end else if (!WB_STALL) begin
               cap      = 1'b1;
               cap_data = resp_data;
               cap_err  = resp_err;
            end else begin
               buf_d     = resp_data;
               buf_err_d = resp_err;
            end
         end
         S_HOLD: begin
            cap      = !WB_STALL;
            cap_data = buf_q;
            cap_err  = buf_err_q;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      wb_v_d     = wb_v_q;
      wb_ir_d    = wb_ir_q;
      wb_npc_d   = wb_npc_q;
      wb_alu_d   = wb_alu_q;
      wb_mem_d   = wb_mem_q;
      wb_rfd_d   = wb_rfd_q;
      wb_csrfd_d = wb_csrfd_q;
      wb_drid_d  = wb_drid_q;
      wb_ecall_d = wb_ecall_q;
      lam_d      = lam_q;
      sam_d      = sam_q;
      laf_d      = laf_q;
      saf_d      = saf_q;
      if (cap) begin
         wb_v_d     = MEM_V;
         wb_ir_d    = MEM_IR;
         wb_npc_d   = MEM_NPC;
         wb_alu_d   = MEM_ALU_RESULT;
         wb_mem_d   = cap_data;
         wb_rfd_d   = MEM_RFD;
         wb_csrfd_d = MEM_CSRFD;
         wb_drid_d  = MEM_DRID;
         wb_ecall_d = MEM_ECALL;
         lam_d      = is_ld && cap_mis;
         sam_d      = is_st && cap_mis;
         laf_d      = is_ld && cap_err;
         saf_d      = is_st && cap_err;
      end else if (!WB_STALL) begin
         // WB moves on while MEM waits: hand it a bubble
         wb_v_d = 1'b0;
         lam_d  = 1'b0;
         sam_d  = 1'b0;
         laf_d  = 1'b0;
         saf_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         timer_q    <= '0;
         buf_q      <= '0;
         buf_err_q  <= 1'b0;
         wb_v_q     <= 1'b0;
         wb_ir_q    <= '0;
         wb_npc_q   <= '0;
         wb_alu_q   <= '0;
         wb_mem_q   <= '0;
         wb_rfd_q   <= '0;
         wb_csrfd_q <= '0;
         wb_drid_q  <= '0;
         wb_ecall_q <= 1'b0;
         lam_q      <= 1'b0;
         sam_q      <= 1'b0;
         laf_q      <= 1'b0;
         saf_q      <= 1'b0;
      end else begin
         timer_q    <= timer_d;
         buf_q      <= buf_d;
         buf_err_q  <= buf_err_d;
         wb_v_q     <= wb_v_d;
         wb_ir_q    <= wb_ir_d;
         wb_npc_q   <= wb_npc_d;
         wb_alu_q   <= wb_alu_d;
         wb_mem_q   <= wb_mem_d;
         wb_rfd_q   <= wb_rfd_d;
         wb_csrfd_q <= wb_csrfd_d;
         wb_drid_q  <= wb_drid_d;
         wb_ecall_q <= wb_ecall_d;
         lam_q      <= lam_d;
         sam_q      <= sam_d;
         laf_q      <= laf_d;
         saf_q      <= saf_d;
      end
   end

   assign WB_V          = wb_v_q;
   assign WB_IR         = wb_ir_q;
   assign WB_NPC        = wb_npc_q;
   assign WB_ALU_RESULT = wb_alu_q;
   assign WB_MEM_RESULT = wb_mem_q;
   assign WB_RFD        = wb_rfd_q;
   assign WB_CSRFD      = wb_csrfd_q;
   assign WB_DRID       = wb_drid_q;
   assign WB_ECALL      = wb_ecall_q;
   assign MEM_LAM       = lam_q;
   assign MEM_SAM       = sam_q;
   assign MEM_LAF       = laf_q;
   assign MEM_SAF       = saf_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised bench for mem_stage_lsu against a
// transaction-level model of the MEM stage.
module tb_mem_stage_lsu;
   import rv_pkg::*;

   localparam int TO = 8;

   logic        CLK = 1'b0;
   logic        RESET, WB_STALL, MEM_V, MEM_ECALL;
   logic [31:0] MEM_IR;
   logic [63:0] MEM_NPC, MEM_ALU_RESULT, MEM_SR1, MEM_SR2;
   logic [63:0] MEM_RFD, MEM_CSRFD;
   logic [4:0]  MEM_DRID;
   logic        DMEM_REQ, DMEM_READY, DMEM_WE;
   logic [63:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
   logic [7:0]  DMEM_WSTRB;
   logic        DMEM_RVALID, DMEM_RERR;
   logic        WB_V, WB_ECALL, WB_PC_MUX;
   logic [31:0] WB_IR;
   logic [63:0] WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT;
   logic [63:0] WB_RFD, WB_CSRFD;
   logic [4:0]  WB_DRID;
   logic        MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF, MEM_STALL;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   mem_stage_lsu #(
      .XLEN(64), .ILEN(32), .RID_W(5), .TIMEOUT(TO)
   ) dut (
      .CLK(CLK), .RESET(RESET), .WB_STALL(WB_STALL),
      .MEM_V(MEM_V), .MEM_IR(MEM_IR), .MEM_NPC(MEM_NPC),
      .MEM_ALU_RESULT(MEM_ALU_RESULT),
      .MEM_SR1(MEM_SR1), .MEM_SR2(MEM_SR2),
      .MEM_RFD(MEM_RFD), .MEM_CSRFD(MEM_CSRFD),
      .MEM_DRID(MEM_DRID), .MEM_ECALL(MEM_ECALL),
      .DMEM_REQ(DMEM_REQ), .DMEM_READY(DMEM_READY),
      .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
      .DMEM_WDATA(DMEM_WDATA), .DMEM_WSTRB(DMEM_WSTRB),
      .DMEM_RVALID(DMEM_RVALID), .DMEM_RDATA(DMEM_RDATA),
      .DMEM_RERR(DMEM_RERR),
      .WB_V(WB_V), .WB_IR(WB_IR), .WB_NPC(WB_NPC),
      .WB_ALU_RESULT(WB_ALU_RESULT),
      .WB_MEM_RESULT(WB_MEM_RESULT),
      .WB_RFD(WB_RFD), .WB_CSRFD(WB_CSRFD),
      .WB_DRID(WB_DRID), .WB_ECALL(WB_ECALL),
      .WB_PC_MUX(WB_PC_MUX),
      .MEM_LAM(MEM_LAM), .MEM_LAF(MEM_LAF),
      .MEM_SAM(MEM_SAM), .MEM_SAF(MEM_SAF),
      .MEM_STALL(MEM_STALL)
   );

   task automatic check_eq(input string tag,
                           input logic [63:0] got,
                           input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   function automatic logic [31:0] mk_ir(input logic [6:0] opc,
                                         input logic [2:0] f3);
      return 32'(opc) | (32'(f3) << 12);
   endfunction

   // bytes gathered one at a time, then sign-filled arithmetically
   function automatic logic [63:0] ref_load(input logic [2:0] f3,
                                            input logic [63:0] addr,
                                            input logic [63:0] rd);
      int n   = 1 << f3[1:0];
      int off = int'(addr % 8);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++)
         v[8*i +: 8] = rd[8*(off+i) +: 8];
      if (!f3[2] && n < 8 && v[8*n-1])
         v = v | (~64'd0 << (8*n));
      return v;
   endfunction

   function automatic logic ref_br(input logic v,
                                   input logic [31:0] ir,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
      logic [6:0] opc = ir[6:0];
      logic [2:0] f3  = ir[14:12];
      if (!v) return 1'b0;
      if (opc == OP_JAL || opc == OP_JALR) return 1'b1;
      if (opc != OP_BRANCH) return 1'b0;
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return longint'(a) < longint'(b);
         3'd5: return longint'(a) >= longint'(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive_misc();
      MEM_NPC   = {$urandom, $urandom};
      MEM_SR1   = {$urandom, $urandom};
      MEM_RFD   = {$urandom, $urandom};
      MEM_CSRFD = {$urandom, $urandom};
      MEM_DRID  = 5'($urandom);
      MEM_ECALL = 1'($urandom);
   endtask

   task automatic do_alu(input logic [31:0] ir,
                         input logic [63:0] a,
                         input logic [63:0] b,
                         input logic v,
                         input int wbs,
                         input logic prev_v);
      logic exp_pc;
      drive_misc();
      MEM_V = v; MEM_IR = ir; MEM_SR1 = a; MEM_SR2 = b;
      MEM_ALU_RESULT = {$urandom, $urandom};
      exp_pc = ref_br(v, ir, a, b);
      for (int s = 0; s < wbs; s++) begin
         WB_STALL = 1'b1;
         mid();
         check_eq("alu_stall", 64'(MEM_STALL), 64'd1);
         step();
         check_eq("alu_wbv_held", 64'(WB_V), 64'(prev_v));
      end
      WB_STALL = 1'b0;
      mid();
      check_eq("pc_mux", 64'(WB_PC_MUX), 64'(exp_pc));
      check_eq("alu_nostall", 64'(MEM_STALL), 64'd0);
      check_eq("alu_noreq", 64'(DMEM_REQ), 64'd0);
      step();
      check_eq("alu_wbv", 64'(WB_V), 64'(v));
      check_eq("alu_npc", WB_NPC, MEM_NPC);
      check_eq("alu_res", WB_ALU_RESULT, MEM_ALU_RESULT);
      check_eq("alu_rfd", WB_RFD, MEM_RFD);
      check_eq("alu_csrfd", WB_CSRFD, MEM_CSRFD);
      check_eq("alu_drid", 64'(WB_DRID), 64'(MEM_DRID));
      check_eq("alu_ecall", 64'(WB_ECALL), 64'(MEM_ECALL));
      check_eq("alu_memres", WB_MEM_RESULT, 64'd0);
   endtask

   task automatic do_mem(input logic st,
                         input logic [2:0] f3,
                         input logic [63:0] addr,
                         input logic [63:0] sr2,
                         input logic [63:0] rdata,
                         input int rdy_dly,
                         input int rsp_dly,
                         input logic err,
                         input int wbs);
      int n = 1 << f3[1:0];
      int off = int'(addr % 8);
      logic mis = (addr % n) != 0;
      logic tmo = rsp_dly > TO;
      int kdone = tmo ? TO : rsp_dly;
      logic fault = tmo || err;
      logic [63:0] exp_res, mask, exp_wd;
      logic [7:0] exp_strb;
      drive_misc();
      MEM_V = 1'b1;
      MEM_IR = mk_ir(st ? OP_STORE : OP_LOAD, f3);
      MEM_ALU_RESULT = addr; MEM_SR2 = sr2;
      WB_STALL = 1'b0; DMEM_RVALID = 1'b0; DMEM_RERR = 1'b0;
      exp_res = (st || fault) ? 64'd0 : ref_load(f3, addr, rdata);
      exp_strb = 8'(((1 << n) - 1) << off);
      mask = '0; exp_wd = '0;
      for (int i = 0; i < n; i++) begin
         mask[8*(off+i) +: 8]   = 8'hFF;
         exp_wd[8*(off+i) +: 8] = sr2[8*i +: 8];
      end
      if (mis) begin
         mid();
         check_eq("mis_noreq", 64'(DMEM_REQ), 64'd0);
         check_eq("mis_nostall", 64'(MEM_STALL), 64'd0);
         step();
         check_eq("mis_wbv", 64'(WB_V), 64'd1);
         check_eq("mis_lam", 64'(MEM_LAM), 64'(!st));
         check_eq("mis_sam", 64'(MEM_SAM), 64'(st));
         check_eq("mis_laf", 64'(MEM_LAF), 64'd0);
         check_eq("mis_memres", WB_MEM_RESULT, 64'd0);
         check_eq("mis_alu", WB_ALU_RESULT, addr);
      end else begin
         for (int c = 0; c <= rdy_dly; c++) begin
            DMEM_READY = (c == rdy_dly);
            mid();
            check_eq("req", 64'(DMEM_REQ), 64'd1);
            check_eq("req_stall", 64'(MEM_STALL), 64'd1);
            check_eq("addr", DMEM_ADDR, addr & ~64'h7);
            check_eq("we", 64'(DMEM_WE), 64'(st));
            if (st) begin
               check_eq("wstrb", 64'(DMEM_WSTRB), 64'(exp_strb));
               check_eq("wdata", DMEM_WDATA & mask, exp_wd);
            end
            step();
         end
         DMEM_READY = 1'b0;
         for (int k = 0; k <= kdone; k++) begin
            if (k == kdone && !tmo) begin
               DMEM_RVALID = 1'b1;
               DMEM_RDATA  = rdata;
               DMEM_RERR   = err;
            end
            WB_STALL = (k == kdone) && (wbs > 0);
            mid();
            check_eq("resp_noreq", 64'(DMEM_REQ), 64'd0);
            check_eq("resp_stall", 64'(MEM_STALL),
                     64'((k < kdone) || (wbs > 0)));
            step();
         end
         DMEM_RVALID = 1'b0; DMEM_RERR = 1'b0;
         for (int s = 1; s < wbs; s++) begin
            WB_STALL = 1'b1;
            mid();
            check_eq("hold_stall", 64'(MEM_STALL), 64'd1);
            step();
            check_eq("hold_wbv", 64'(WB_V), 64'd0);
         end
         if (wbs > 0) begin
            WB_STALL = 1'b0;
            mid();
            check_eq("hold_release", 64'(MEM_STALL), 64'd0);
            check_eq("hold_wbv0", 64'(WB_V), 64'd0);
            step();
         end
         check_eq("mem_wbv", 64'(WB_V), 64'd1);
         check_eq("mem_res", WB_MEM_RESULT, exp_res);
         check_eq("mem_laf", 64'(MEM_LAF), 64'(!st && fault));
         check_eq("mem_saf", 64'(MEM_SAF), 64'(st && fault));
         check_eq("mem_lam", 64'(MEM_LAM), 64'd0);
         check_eq("mem_alu", WB_ALU_RESULT, addr);
         check_eq("mem_rfd", WB_RFD, MEM_RFD);
      end
      // bubble next; a late response here must be dropped
      MEM_V = 1'b0;
      DMEM_RVALID = tmo;
      mid();
      check_eq("post_noreq", 64'(DMEM_REQ), 64'd0);
      check_eq("post_nostall", 64'(MEM_STALL), 64'd0);
      step();
      DMEM_RVALID = 1'b0;
      check_eq("post_wbv", 64'(WB_V), 64'd0);
      check_eq("post_laf", 64'(MEM_LAF), 64'd0);
   endtask

   task automatic reset_during(input logic in_resp);
      drive_misc();
      MEM_V = 1'b1; MEM_IR = mk_ir(OP_LOAD, 3'b011);
      MEM_ALU_RESULT = 64'h3000; WB_STALL = 1'b0;
      DMEM_READY = in_resp;
      step();
      DMEM_READY = 1'b0;
      mid();
      check_eq("rst_pre_req", 64'(DMEM_REQ), 64'(!in_resp));
      RESET = 1'b1;
      #1;
      check_eq("rst_req_drop", 64'(DMEM_REQ), 64'd0);
      step();
      check_eq("rst_wbv", 64'(WB_V), 64'd0);
      check_eq("rst_alu", WB_ALU_RESULT, 64'd0);
      check_eq("rst_npc", WB_NPC, 64'd0);
      check_eq("rst_laf", 64'(MEM_LAF), 64'd0);
      RESET = 1'b0; MEM_V = 1'b0;
      DMEM_RVALID = 1'b1; DMEM_RDATA = 64'hDEAD;
      mid();
      check_eq("rst_idle", 64'(MEM_STALL), 64'd0);
      step();
      DMEM_RVALID = 1'b0;
      check_eq("rst_stale", 64'(WB_V), 64'd0);
      check_eq("rst_stale_laf", 64'(MEM_LAF), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [6:0] alu_ops [6];
      logic last_v;
      alu_ops = '{OP_BRANCH, OP_JAL, OP_JALR,
                  7'h33, 7'h13, 7'h73};
      RESET = 1'b1; WB_STALL = 1'b0; MEM_V = 1'b0;
      MEM_IR = '0; MEM_NPC = '0; MEM_ALU_RESULT = '0;
      MEM_SR1 = '0; MEM_SR2 = '0; MEM_RFD = '0;
      MEM_CSRFD = '0; MEM_DRID = '0; MEM_ECALL = 1'b0;
      DMEM_READY = 1'b0; DMEM_RVALID = 1'b0;
      DMEM_RDATA = '0; DMEM_RERR = 1'b0;
      step(); step();
      check_eq("rst_wbv0", 64'(WB_V), 64'd0);
      check_eq("rst_memres0", WB_MEM_RESULT, 64'd0);
      check_eq("rst_flags0",
               64'({MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF}), 64'd0);
      check_eq("rst_req0", 64'(DMEM_REQ), 64'd0);
      RESET = 1'b0;
      mid();
      check_eq("rst_stall0", 64'(MEM_STALL), 64'd0);

      do_alu(mk_ir(OP_BRANCH, F3_BLT), -64'sd1, 64'd1, 1'b1, 0, 1'b0);
      do_alu(mk_ir(OP_BRANCH, F3_BLTU), -64'sd1, 64'd1, 1'b1, 0, 1'b1);
      do_alu(mk_ir(OP_BRANCH, F3_BGE), 64'd5, 64'd5, 1'b1, 1, 1'b1);
      do_alu(mk_ir(OP_BRANCH, 3'b010), 64'd5, 64'd5, 1'b1, 0, 1'b1);
      do_alu(mk_ir(OP_JAL, 3'b000), 64'd0, 64'd0, 1'b0, 0, 1'b1);
      do_alu(mk_ir(OP_JALR, 3'b000), 64'd0, 64'd0, 1'b1, 0, 1'b0);

      do_mem(1'b0, F3_LB, 64'h1003, 0, 64'h0000_0000_8000_0000,
             0, 0, 1'b0, 0);
      do_mem(1'b0, F3_LBU, 64'h1003, 0, 64'h0000_0000_8000_0000,
             0, 0, 1'b0, 0);
      do_mem(1'b1, 3'b001, 64'h2006, 64'hABCD, 0, 0, 0, 1'b0, 0);
      do_mem(1'b0, F3_LW, 64'h1002, 0, 0, 0, 0, 1'b0, 0);
      do_mem(1'b0, 3'b011, 64'h4008, 0, 64'h0123_4567_89AB_CDEF,
             3, 0, 1'b0, 2);
      do_mem(1'b0, F3_LW, 64'h5004, 0, 64'h1, 0, TO + 3, 1'b0, 0);
      do_mem(1'b1, 3'b010, 64'h6004, 64'h1234, 0, 1, 1, 1'b1, 0);
      reset_during(1'b1);
      reset_during(1'b0);

      last_v = 1'b0;
      for (int t = 0; t < 200; t++) begin
         if ($urandom_range(1, 0) == 0) begin
            logic [31:0] ir;
            logic [63:0] a, b;
            logic v;
            ir = mk_ir(alu_ops[$urandom_range(5, 0)],
                       3'($urandom));
            a = {$urandom, $urandom};
            b = ($urandom_range(1, 0) == 0) ? a
              : {$urandom, $urandom};
            v = ($urandom_range(7, 0) != 0);
            do_alu(ir, a, b, v, $urandom_range(2, 0), last_v);
            last_v = v;
         end else begin
            logic st;
            logic [2:0] f3;
            st = 1'($urandom);
            f3 = st ? 3'($urandom_range(3, 0))
                    : 3'($urandom_range(6, 0));
            do_mem(st, f3, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(3, 0),
                   ($urandom_range(7, 0) == 0) ? TO + 3
                                              : $urandom_range(3, 0),
                   ($urandom_range(7, 0) == 0),
                   $urandom_range(2, 0));
            last_v = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
